// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier: one conditional add per clock, producing a
// full 2*num_bits product from two num_bits operands. A start/done handshake
// frames each operation; busy is high for the whole operation.
//
// Optional feature macro: SEQ_MULT_SIGNED_EN
//   defined   -> signed_op port exists; two's-complement operands are handled
//                by multiplying magnitudes and negating the result at the end.
//   undefined -> no signed_op port; operands are always unsigned.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request a multiply (sampled only in IDLE)
//   a, b       multiplicand / multiplier, captured when start is accepted
//   signed_op  two's-complement mode (only with SEQ_MULT_SIGNED_EN)
//   busy       high whenever the unit is not IDLE
//   done       one-cycle pulse, product valid
//   product    registered result, held until the next operation completes
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int num_bits = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [num_bits-1:0]       a,
    input  logic [num_bits-1:0]       b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                      signed_op,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [2*num_bits-1:0]     product
);

    localparam int W2 = 2 * num_bits;
    localparam int CW = $clog2(num_bits + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Last iteration is the one where count moves from N-1 to N.
    localparam logic [CW-1:0] CNT_LAST = CW'(num_bits - 1);

    logic [1:0]          state_q,   state_d;
    logic [W2-1:0]       mcand_q,   mcand_d;
    logic [num_bits-1:0] mplier_q,  mplier_d;
    logic [W2-1:0]       acc_q,     acc_d;
    logic [CW-1:0]       count_q,   count_d;
    logic [W2-1:0]       product_q, product_d;

    logic [num_bits-1:0] a_eff_s;
    logic [num_bits-1:0] b_eff_s;
    logic [W2-1:0]       acc_sum_s;
    logic [W2-1:0]       result_s;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitude of a two's-complement value; -2^(N-1) maps to unsigned 2^(N-1).
    function automatic logic [num_bits-1:0] abs_val(input logic [num_bits-1:0] v);
        logic [num_bits-1:0] r;
        if (v[num_bits-1]) begin
            r = ~v + {{(num_bits-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation of the double-width accumulator.
    function automatic logic [W2-1:0] negate_w2(input logic [W2-1:0] v);
        return ~v + {{(W2-1){1'b0}}, 1'b1};
    endfunction
`endif

    // Next-state, datapath and operand-conditioning logic.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d     = neg_q;
        if (signed_op) begin
            a_eff_s = abs_val(a);
            b_eff_s = abs_val(b);
        end else begin
            a_eff_s = a;
            b_eff_s = b;
        end
`else
        a_eff_s   = a;
        b_eff_s   = b;
`endif

        acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {W2{1'b0}});

`ifdef SEQ_MULT_SIGNED_EN
        if (neg_q) begin
            result_s = negate_w2(acc_sum_s);
        end else begin
            result_s = acc_sum_s;
        end
`else
        result_s  = acc_sum_s;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = {{num_bits{1'b0}}, a_eff_s};
                    mplier_d = b_eff_s;
                    acc_d    = {W2{1'b0}};
                    count_d  = CNT_ZERO;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d    = signed_op & (a[num_bits-1] ^ b[num_bits-1]);
`endif
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    // Final add folds straight into product on the DONE-entry edge.
                    product_d = result_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= {W2{1'b0}};
            mplier_q  <= {num_bits{1'b0}};
            acc_q     <= {W2{1'b0}};
            count_q   <= CNT_ZERO;
            product_q <= {W2{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    // Outputs come only from flops or state decode.
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier: an 8-bit instance for the bulk of
// the scenarios and a 32-bit instance for the wide case. Expected products come
// from plain integer multiplication of the captured operands.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int N  = 8;
    localparam int NW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              start;
    logic [N-1:0]      a;
    logic [N-1:0]      b;
    logic              busy;
    logic              done;
    logic [2*N-1:0]    product;

    logic              start_w;
    logic [NW-1:0]     a_w;
    logic [NW-1:0]     b_w;
    logic              busy_w;
    logic              done_w;
    logic [2*NW-1:0]   product_w;

`ifdef SEQ_MULT_SIGNED_EN
    logic              signed_op;
    logic              signed_op_w;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    seq_multiplier #(.num_bits(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (signed_op),
`endif
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    seq_multiplier #(.num_bits(NW)) dut_w (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start_w),
        .a         (a_w),
        .b         (b_w),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (signed_op_w),
`endif
        .busy      (busy_w),
        .done      (done_w),
        .product   (product_w)
    );

    // Reference: full-width integer product of the operands as the user sees them.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic s);
        logic signed [2*N-1:0] sx;
        logic signed [2*N-1:0] sy;
        logic [2*N-1:0]        ux;
        logic [2*N-1:0]        uy;
        sx = {{N{x[N-1]}}, x};
        sy = {{N{y[N-1]}}, y};
        ux = {{N{1'b0}}, x};
        uy = {{N{1'b0}}, y};
        if (s) return sx * sy;
        else   return ux * uy;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the 8-bit unit and observe its handshake.
    task automatic do_mul(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic si,
                          output logic [2*N-1:0] p, output int lat,
                          output logic busy_e1, output logic busy_gap,
                          output logic held, output logic done_after, output logic busy_after);
        logic [2*N-1:0] prev;
        prev = product;
        a = ai;
        b = bi;
`ifdef SEQ_MULT_SIGNED_EN
        signed_op = si;
`else
        if (si) $display("[TB] note: signed request ignored in unsigned build");
`endif
        start = 1'b1;
        step;
        start = 1'b0;
        // Inputs are free to wander once accepted.
        a = 8'($urandom);
        b = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        signed_op = 1'($urandom);
`endif
        busy_e1  = busy;
        busy_gap = 1'b0;
        held     = 1'b1;
        lat      = 0;
        do begin
            if (product !== prev) held = 1'b0;
            step;
            lat++;
            if (!busy) busy_gap = 1'b1;
        end while (!done && lat < 100);
        p = product;
        step;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        start_w = 1'b0;
        a = '0; b = '0; a_w = '0; b_w = '0;
`ifdef SEQ_MULT_SIGNED_EN
        signed_op = 1'b0; signed_op_w = 1'b0;
`endif
        step; step;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
        n_tests++; if (product_w !== 64'h0) begin n_fail++; $display("FAIL reset_product_w got %h want 0", product_w); end
        @(negedge clk);
        reset_n = 1'b1;
        step;
    endtask

    task automatic test_directed;
        logic [N-1:0] ta [3];
        logic [N-1:0] tb [3];
        logic [2*N-1:0] p;
        int lat;
        logic be1, bgap, held, da, ba;
        ta = '{8'd13, 8'd255, 8'd0};
        tb = '{8'd11, 8'd255, 8'hA5};
        for (int i = 0; i < 3; i++) begin
            do_mul(ta[i], tb[i], 1'b0, p, lat, be1, bgap, held, da, ba);
            n_tests++; if (p !== ref_mul(ta[i], tb[i], 1'b0)) begin n_fail++; $display("FAIL dir_product[%0d] got %h want %h", i, p, ref_mul(ta[i], tb[i], 1'b0)); end
            n_tests++; if (lat !== N) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, N); end
            n_tests++; if (be1 !== 1'b1) begin n_fail++; $display("FAIL dir_busy_rise[%0d] got %b want 1", i, be1); end
            n_tests++; if (bgap !== 1'b0) begin n_fail++; $display("FAIL dir_busy_gap[%0d] got %b want 0", i, bgap); end
            n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL dir_product_hold[%0d] got %b want 1", i, held); end
            n_tests++; if (da !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d] got %b want 0", i, da); end
            n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL dir_busy_fall[%0d] got %b want 0", i, ba); end
        end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL dir_zero_product got %h want 0000", product); end
    endtask

    task automatic test_random;
        logic [N-1:0] x, y;
        logic s;
        logic [2*N-1:0] p;
        int lat;
        logic be1, bgap, held, da, ba;
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_mul(x, y, s, p, lat, be1, bgap, held, da, ba);
            n_tests++; if (p !== ref_mul(x, y, s)) begin n_fail++; $display("FAIL rnd_product a=%h b=%h s=%b got %h want %h", x, y, s, p, ref_mul(x, y, s)); end
            n_tests++; if (lat !== N || da !== 1'b0) begin n_fail++; $display("FAIL rnd_timing latency got %0d want %0d done_after %b", lat, N, da); end
        end
    endtask

    task automatic test_start_held;
        int e;
        a = 8'd3;
        b = 8'd4;
`ifdef SEQ_MULT_SIGNED_EN
        signed_op = 1'b0;
`endif
        start = 1'b1;
        step;                       // E0
        e = 0;
        do begin
            step;
            e++;
            if (e == 3) a = 8'd7;
        end while (!done && e < 100);
        n_tests++; if (product !== 16'h000C) begin n_fail++; $display("FAIL held_first_product got %h want 000C", product); end
        n_tests++; if (e !== N) begin n_fail++; $display("FAIL held_first_latency got %0d want %0d", e, N); end
        step;                       // E9: back to IDLE, start not yet taken
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap busy got %b want 0", busy); end
        step;                       // E10: accepted again
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_reaccept busy got %b want 1", busy); end
        e = 0;
        do begin
            step;
            e++;
        end while (!done && e < 100);
        start = 1'b0;
        n_tests++; if (product !== 16'd28) begin n_fail++; $display("FAIL held_second_product got %h want 001C", product); end
        n_tests++; if (e !== N) begin n_fail++; $display("FAIL held_second_latency got %0d want %0d", e, N); end
        step;
        step;
    endtask

    task automatic test_reset_mid;
        logic [2*N-1:0] p;
        int lat;
        logic be1, bgap, held, da, ba;
        a = 8'd200;
        b = 8'd200;
        start = 1'b1;
        step;                       // E0
        start = 1'b0;
        for (int i = 0; i < 4; i++) step;   // through E4
        reset_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL midrst_product got %h want 0000", product); end
        @(negedge clk);
        reset_n = 1'b1;
        step;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resume busy got %b want 0", busy); end
        do_mul(8'd2, 8'd3, 1'b0, p, lat, be1, bgap, held, da, ba);
        n_tests++; if (p !== 16'h0006) begin n_fail++; $display("FAIL midrst_fresh_product got %h want 0006", p); end
        n_tests++; if (lat !== N) begin n_fail++; $display("FAIL midrst_fresh_latency got %0d want %0d", lat, N); end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed;
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        logic         ts [4];
        logic [2*N-1:0] want [4];
        logic [2*N-1:0] p;
        int lat;
        logic be1, bgap, held, da, ba;
        ta   = '{8'hFD, 8'h80, 8'h80, 8'hFD};
        tb   = '{8'h05, 8'h80, 8'h01, 8'h05};
        ts   = '{1'b1, 1'b1, 1'b1, 1'b0};
        want = '{16'hFFF1, 16'h4000, 16'hFF80, 16'h04F1};
        for (int i = 0; i < 4; i++) begin
            do_mul(ta[i], tb[i], ts[i], p, lat, be1, bgap, held, da, ba);
            n_tests++; if (p !== want[i]) begin n_fail++; $display("FAIL signed_product[%0d] got %h want %h", i, p, want[i]); end
            n_tests++; if (lat !== N) begin n_fail++; $display("FAIL signed_latency[%0d] got %0d want %0d", i, lat, N); end
        end
    endtask
`endif

    task automatic test_wide;
        logic [NW-1:0] xa [3];
        logic [NW-1:0] xb [3];
        logic [2*NW-1:0] want;
        int lat;
        xa = '{32'hFFFF_FFFF, $urandom, $urandom};
        xb = '{32'h0000_0002, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            want = {32'h0, xa[i]} * {32'h0, xb[i]};
            a_w = xa[i];
            b_w = xb[i];
`ifdef SEQ_MULT_SIGNED_EN
            signed_op_w = 1'b0;
`endif
            start_w = 1'b1;
            step;
            start_w = 1'b0;
            a_w = $urandom;
            b_w = $urandom;
            lat = 0;
            do begin
                step;
                lat++;
            end while (!done_w && lat < 200);
            n_tests++; if (product_w !== want) begin n_fail++; $display("FAIL wide_product[%0d] got %h want %h", i, product_w, want); end
            n_tests++; if (lat !== NW) begin n_fail++; $display("FAIL wide_latency[%0d] got %0d want %0d", i, lat, NW); end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_held;
        test_reset_mid;
`ifdef SEQ_MULT_SIGNED_EN
        test_signed;
`endif
        test_wide;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
